free_list: RTL and testbench
============================

Name: free_list

Overview:
- Two-wide circular free list of physical register tags for the R10K-style rename datapath.
- Supplies new tags (Tnew) to the two dispatch ways.
- Reclaims old tags (Told) from the two retire ways in the same cycle that retirement updates the architectural map table.
- On a retire-time rollback, restores the free pool to exactly the architectural free set.

Parameters:
- N_PHYS_REG, default `N_ENTRY_ROB+33 rounded down to 64; total physical registers. Tags 0..31 are the reset architectural mappings; tags 32..N_PHYS_REG-1 start free.
- N_FREE, default N_PHYS_REG-32; free-list depth. Must be a power of 2.
- TAG_W, default $clog2(N_PHYS_REG); tag width.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- dispatch_req_0, input, 1: way-0 dispatch needs a destination tag.
- dispatch_req_1, input, 1: way-1 dispatch needs a destination tag.
- Tnew_0, output, TAG_W: tag granted to way 0.
- Tnew_1, output, TAG_W: tag granted to way 1.
- free_num, output, 2: min(count, 2); dispatch stall input.
- free_count, output, $clog2(N_FREE+1): current number of free tags.
- valid_0, input, 1: retire way 0 frees Told_out_0.
- valid_1, input, 1: retire way 1 frees Told_out_1.
- Told_out_0, input, TAG_W: tag freed by retire way 0.
- Told_out_1, input, TAG_W: tag freed by retire way 1.
- rollback, input, 1: retire-time mispredict/exception squash.
- overflow_err, output, 1: a push was attempted while the list was full.

Behaviour:
- Storage: circular buffer fl[N_FREE] of TAG_W tags, with head (pop), tail (push) and count (0..N_FREE).
- Reset (async, active-high):
  - fl[i] = 32+i; head = 0; tail = 0; count = N_FREE.
  - overflow_err = 0; free_num = 2; free_count = N_FREE.
  - Tnew_0 = 32, Tnew_1 = 33.
- Pop (combinational outputs):
  - Tnew_0 = fl[head].
  - Tnew_1 = fl[head + dispatch_req_0] (mod N_FREE).
  - A request with only way 1 therefore takes fl[head].
- Pop (commit at posedge):
  - pops = req_0 + req_1, applied only if pops <= count.
  - If pops > count, no pop occurs. Dispatch is required to respect free_num, so this case is a protocol violation.
  - head += pops.
- Push:
  - Way 0 is written first at tail, then way 1 at tail+valid_0.
  - tail += valid_0 + valid_1.
  - Upstream asserts valid_x only for retiring instructions that have a non-zero destination.
- Count: count_next = count - pops + pushes, evaluated from current-cycle values.
- No same-cycle bypass: tags freed in cycle N become allocatable in cycle N+1. free_num reflects registered count only.
- Overflow:
  - If count - pops + pushes > N_FREE, the excess pushes are dropped.
  - overflow_err is asserted for that cycle (registered, 1-cycle pulse). State stays consistent.
- Rollback (takes priority over dispatch):
  - Same-cycle pops are ignored.
  - Same-cycle retire pushes are still applied.
  - Then head_next = tail_next and count_next = N_FREE. This is correct because the architectural free set is always exactly N_FREE tags, located in the N_FREE slots ending at tail.
- Wrap-around: all pointers wrap modulo N_FREE, including two-entry pushes or pops that straddle the wrap point.
- Latency: Tnew is valid in the same cycle as the request; pointer updates are visible the next cycle.
- Reset mid-operation: all state returns to the reset values immediately, independent of the clock.

Test Plan (N_PHYS_REG=64, N_FREE=32):
- Reset, then req_0=req_1=1 for 1 cycle: Tnew_0=32, Tnew_1=33 → next cycle free_count=30, Tnew_0=34.
- req_1 only after reset: Tnew_1=32 → next cycle Tnew_0=33, free_count=31.
- Drain to count=1: free_num=1. Push Told 5 via valid_0 in the same cycle as req_0 → pop granted tag, free_count stays 1, next Tnew_0=5 (no bypass).
- Allocate 40 and retire 40 pairs across the wrap point: FIFO order is preserved and free_count returns to 32.
- Allocate 6, retire 2 (Told 7, 9), assert rollback with req_0=1 and valid_0 (Told 11) → next free_count=32, head==tail, no pop applied.
- At full (count=32), valid_0=valid_1=1 → overflow_err=1 for one cycle, count stays 32. Assert reset asynchronously mid-stream → outputs return to reset values before the next clock edge.

Source files
------------

// File: rtl/free_list.sv
`default_nettype none
// ============================================================================
// free_list : two-wide circular free list of physical register tags
//             (two dispatch pops, two retire pushes, retire-time rollback)
// Revision  : 1.0
// ============================================================================
module free_list #(
    parameter int N_PHYS_REG = 64,
    parameter int N_FREE     = N_PHYS_REG - 32,
    parameter int TAG_W      = $clog2(N_PHYS_REG)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        dispatch_req_0,
    input  logic                        dispatch_req_1,
    output logic [TAG_W-1:0]            Tnew_0,
    output logic [TAG_W-1:0]            Tnew_1,
    output logic [1:0]                  free_num,
    output logic [$clog2(N_FREE+1)-1:0] free_count,
    input  logic                        valid_0,
    input  logic                        valid_1,
    input  logic [TAG_W-1:0]            Told_out_0,
    input  logic [TAG_W-1:0]            Told_out_1,
    input  logic                        rollback,
    output logic                        overflow_err
);

    localparam int PTR_W = $clog2(N_FREE);
    localparam int CNT_W = $clog2(N_FREE + 1);

    logic [TAG_W-1:0] fl [N_FREE];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             overflow_q;

    logic [1:0]       pops;
    logic             pop_ok;
    logic [1:0]       popped;
    logic [CNT_W-1:0] after_pop;
    logic [CNT_W-1:0] room;
    logic             acc_0;
    logic             acc_1;
    logic [1:0]       pushed;
    logic             dropped;
    logic [PTR_W-1:0] wr1_idx;
    logic [PTR_W-1:0] tail_next;
    logic [PTR_W-1:0] head_next;
    logic [CNT_W-1:0] count_next;

    // Way 1 reads the slot after way 0 only when way 0 also pops.
    assign Tnew_0     = fl[head];
    assign Tnew_1     = fl[head + PTR_W'(dispatch_req_0)];
    assign free_count = count;
    assign free_num   = (count >= CNT_W'(2)) ? 2'd2 : count[1:0];
    assign overflow_err = overflow_q;

    always_comb begin
        pops      = {1'b0, dispatch_req_0} + {1'b0, dispatch_req_1};
        pop_ok    = !rollback && (CNT_W'(pops) <= count);
        popped    = pop_ok ? pops : 2'd0;
        after_pop = count - CNT_W'(popped);
        // Pushes beyond the free capacity left after popping are dropped.
        room      = CNT_W'(N_FREE) - after_pop;
        acc_0     = valid_0 && (room != '0);
        acc_1     = valid_1 && (room > CNT_W'(acc_0));
        dropped   = (valid_0 && !acc_0) || (valid_1 && !acc_1);
        pushed    = {1'b0, acc_0} + {1'b0, acc_1};
        wr1_idx   = tail + PTR_W'(acc_0);
        tail_next = tail + PTR_W'(pushed);
        // The architectural free set is always the N_FREE slots ending at tail.
        head_next  = rollback ? tail_next : head + PTR_W'(popped);
        count_next = rollback ? CNT_W'(N_FREE) : after_pop + CNT_W'(pushed);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_FREE; i++) begin
                fl[i] <= TAG_W'(32 + i);
            end
            head       <= '0;
            tail       <= '0;
            count      <= CNT_W'(N_FREE);
            overflow_q <= 1'b0;
        end else begin
            if (acc_0) begin
                fl[tail] <= Told_out_0;
            end
            if (acc_1) begin
                fl[wr1_idx] <= Told_out_1;
            end
            head       <= head_next;
            tail       <= tail_next;
            count      <= count_next;
            overflow_q <= dropped;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_free_list.sv
`default_nettype none
// ============================================================================
// tb_free_list : directed self-checking bench for free_list (64 regs, 32 free)
// Revision     : 1.0
// ============================================================================
module tb_free_list;

    localparam int TAG_W = 6;

    logic             clock = 1'b0;
    logic             reset;
    logic             dispatch_req_0, dispatch_req_1;
    logic [TAG_W-1:0] Tnew_0, Tnew_1;
    logic [1:0]       free_num;
    logic [5:0]       free_count;
    logic             valid_0, valid_1;
    logic [TAG_W-1:0] Told_out_0, Told_out_1;
    logic             rollback;
    logic             overflow_err;

    int errors = 0;
    int checks = 0;

    free_list #(.N_PHYS_REG(64)) dut (
        .clock          (clock),
        .reset          (reset),
        .dispatch_req_0 (dispatch_req_0),
        .dispatch_req_1 (dispatch_req_1),
        .Tnew_0         (Tnew_0),
        .Tnew_1         (Tnew_1),
        .free_num       (free_num),
        .free_count     (free_count),
        .valid_0        (valid_0),
        .valid_1        (valid_1),
        .Told_out_0     (Told_out_0),
        .Told_out_1     (Told_out_1),
        .rollback       (rollback),
        .overflow_err   (overflow_err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        dispatch_req_0 = 1'b0;
        dispatch_req_1 = 1'b0;
        valid_0        = 1'b0;
        valid_1        = 1'b0;
        Told_out_0     = '0;
        Told_out_1     = '0;
        rollback       = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        idle();
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        #1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic pop_cycles(input int n, input logic both);
        for (int i = 0; i < n; i++) begin
            dispatch_req_0 = 1'b1;
            dispatch_req_1 = both;
            step();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL reset_count: got %0d expected 32", free_count); end
        checks++; if (free_num !== 2'd2) begin errors++; $display("FAIL reset_free_num: got %0d expected 2", free_num); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow_err); end
        checks++; if (Tnew_0 !== 6'd32) begin errors++; $display("FAIL reset_tnew0: got %0d expected 32", Tnew_0); end
        dispatch_req_0 = 1'b1;
        #1;
        checks++; if (Tnew_1 !== 6'd33) begin errors++; $display("FAIL reset_tnew1: got %0d expected 33", Tnew_1); end
        idle();
        #1;
    endtask

    task automatic test_dual_pop();
        do_reset();
        dispatch_req_0 = 1'b1;
        dispatch_req_1 = 1'b1;
        #1;
        checks++; if (Tnew_0 !== 6'd32 || Tnew_1 !== 6'd33) begin errors++; $display("FAIL dual_pop_tags: got %0d,%0d expected 32,33", Tnew_0, Tnew_1); end
        step();
        checks++; if (free_count !== 6'd30) begin errors++; $display("FAIL dual_pop_count: got %0d expected 30", free_count); end
        checks++; if (Tnew_0 !== 6'd34) begin errors++; $display("FAIL dual_pop_next: got %0d expected 34", Tnew_0); end
    endtask

    task automatic test_way1_only();
        do_reset();
        dispatch_req_1 = 1'b1;
        #1;
        checks++; if (Tnew_1 !== 6'd32) begin errors++; $display("FAIL way1_tag: got %0d expected 32", Tnew_1); end
        step();
        checks++; if (Tnew_0 !== 6'd33) begin errors++; $display("FAIL way1_next: got %0d expected 33", Tnew_0); end
        checks++; if (free_count !== 6'd31) begin errors++; $display("FAIL way1_count: got %0d expected 31", free_count); end
    endtask

    task automatic test_drain_no_bypass();
        do_reset();
        pop_cycles(15, 1'b1);
        checks++; if (free_num !== 2'd2 || free_count !== 6'd2) begin errors++; $display("FAIL drain_two: got num=%0d count=%0d expected 2,2", free_num, free_count); end
        pop_cycles(1, 1'b0);
        checks++; if (free_num !== 2'd1 || free_count !== 6'd1) begin errors++; $display("FAIL drain_one: got num=%0d count=%0d expected 1,1", free_num, free_count); end
        dispatch_req_0 = 1'b1;
        valid_0        = 1'b1;
        Told_out_0     = 6'd5;
        #1;
        checks++; if (Tnew_0 !== 6'd63) begin errors++; $display("FAIL drain_last_tag: got %0d expected 63", Tnew_0); end
        step();
        checks++; if (free_count !== 6'd1) begin errors++; $display("FAIL nobypass_count: got %0d expected 1", free_count); end
        checks++; if (Tnew_0 !== 6'd5) begin errors++; $display("FAIL nobypass_tag: got %0d expected 5", Tnew_0); end
        // two requests against one free tag must not pop
        pop_cycles(1, 1'b1);
        checks++; if (free_count !== 6'd1 || Tnew_0 !== 6'd5) begin errors++; $display("FAIL underflow_hold: got count=%0d tag=%0d expected 1,5", free_count, Tnew_0); end
    endtask

    task automatic test_wrap();
        int q[$];
        int e0, e1;
        int bad;
        do_reset();
        pop_cycles(2, 1'b1);
        for (int i = 36; i < 64; i++) q.push_back(i);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            e0 = q.pop_front();
            e1 = q.pop_front();
            dispatch_req_0 = 1'b1;
            dispatch_req_1 = 1'b1;
            valid_0        = 1'b1;
            valid_1        = 1'b1;
            Told_out_0     = TAG_W'(e0);
            Told_out_1     = TAG_W'(e1);
            #1;
            checks++;
            if (int'(Tnew_0) != e0 || int'(Tnew_1) != e1) begin
                errors++;
                if (bad < 4) $display("FAIL wrap_order[%0d]: got %0d,%0d expected %0d,%0d", c, Tnew_0, Tnew_1, e0, e1);
                bad++;
            end
            q.push_back(e0);
            q.push_back(e1);
            step();
        end
        checks++; if (free_count !== 6'd28) begin errors++; $display("FAIL wrap_steady_count: got %0d expected 28", free_count); end
        for (int k = 0; k < 2; k++) begin
            valid_0    = 1'b1;
            valid_1    = 1'b1;
            Told_out_0 = TAG_W'(32 + 2 * k);
            Told_out_1 = TAG_W'(33 + 2 * k);
            q.push_back(32 + 2 * k);
            q.push_back(33 + 2 * k);
            step();
        end
        checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL wrap_final_count: got %0d expected 32", free_count); end
        checks++; if (int'(Tnew_0) != q[0]) begin errors++; $display("FAIL wrap_final_head: got %0d expected %0d", Tnew_0, q[0]); end
    endtask

    task automatic test_rollback();
        do_reset();
        pop_cycles(3, 1'b1);
        valid_0    = 1'b1;
        valid_1    = 1'b1;
        Told_out_0 = 6'd7;
        Told_out_1 = 6'd9;
        step();
        checks++; if (free_count !== 6'd28) begin errors++; $display("FAIL rb_pre_count: got %0d expected 28", free_count); end
        rollback       = 1'b1;
        dispatch_req_0 = 1'b1;
        valid_0        = 1'b1;
        Told_out_0     = 6'd11;
        step();
        checks++; if (free_count !== 6'd32) begin errors++; $display("FAIL rb_count: got %0d expected 32", free_count); end
        checks++; if (Tnew_0 !== 6'd35) begin errors++; $display("FAIL rb_head: got %0d expected 35", Tnew_0); end
        pop_cycles(14, 1'b1);
        pop_cycles(1, 1'b0);
        dispatch_req_0 = 1'b1;
        #1;
        checks++; if (Tnew_0 !== 6'd7 || Tnew_1 !== 6'd9) begin errors++; $display("FAIL rb_retired_tags: got %0d,%0d expected 7,9", Tnew_0, Tnew_1); end
        dispatch_req_1 = 1'b1;
        step();
        checks++; if (Tnew_0 !== 6'd11 || free_count !== 6'd1) begin errors++; $display("FAIL rb_rollback_push: got tag=%0d count=%0d expected 11,1", Tnew_0, free_count); end
    endtask

    task automatic test_overflow_async_reset();
        do_reset();
        valid_0    = 1'b1;
        valid_1    = 1'b1;
        Told_out_0 = 6'd1;
        Told_out_1 = 6'd2;
        step();
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %0b expected 1", overflow_err); end
        checks++; if (free_count !== 6'd32 || Tnew_0 !== 6'd32) begin errors++; $display("FAIL ovf_state: got count=%0d tag=%0d expected 32,32", free_count, Tnew_0); end
        step();
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0b expected 0", overflow_err); end
        pop_cycles(1, 1'b1);
        valid_0    = 1'b1;
        valid_1    = 1'b1;
        Told_out_0 = 6'd3;
        Told_out_1 = 6'd4;
        step();
        valid_0    = 1'b1;
        valid_1    = 1'b1;
        Told_out_0 = 6'd5;
        Told_out_1 = 6'd6;
        step();
        checks++; if (overflow_err !== 1'b1 || Tnew_0 !== 6'd34) begin errors++; $display("FAIL pre_reset_state: got ovf=%0b tag=%0d expected 1,34", overflow_err, Tnew_0); end
        reset = 1'b1;
        #1;
        checks++; if (overflow_err !== 1'b0 || free_count !== 6'd32 || free_num !== 2'd2) begin errors++; $display("FAIL async_reset_ctrl: got ovf=%0b count=%0d num=%0d expected 0,32,2", overflow_err, free_count, free_num); end
        dispatch_req_0 = 1'b1;
        #1;
        checks++; if (Tnew_0 !== 6'd32 || Tnew_1 !== 6'd33) begin errors++; $display("FAIL async_reset_tags: got %0d,%0d expected 32,33", Tnew_0, Tnew_1); end
        idle();
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_dual_pop();
        test_way1_only();
        test_drain_no_bypass();
        test_wrap();
        test_rollback();
        test_overflow_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
